// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and LFSR tap table for the random-grant arbiter.
package rng_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int BITS_DEF    = 5;
    localparam int CNT_W       = 16;
    localparam int RNG_SEED    = 22;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

    // Fibonacci feedback taps (bit i set => q[i] feeds the XOR); maximal-length up to 8 bits.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            default: return 32'h0000_0003 << (w - 2);
        endcase
    endfunction
endpackage

// File: rtl/rng_arbiter_if.sv
// Request/grant bundle between the requesters and the random-value arbiter.
interface rng_arbiter_if import rng_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int BITS    = BITS_DEF
);
    logic                 pause;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [BITS-1:0]      rnd_out;
    logic [CNT_W-1:0]     grant_count;

    modport master (output pause, req, input gnt, rnd_out, grant_count);
    modport slave  (input pause, req, output gnt, rnd_out, grant_count);
endinterface

// File: rtl/rng_arbiter_rng.sv
// Free-running Fibonacci LFSR; restarts from the seed on reset and never stalls.
module pseudo_rng import rng_pkg::*; #(
    parameter int BITS = BITS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [BITS-1:0] rnd
);
    localparam logic [BITS-1:0] TAPS = BITS'(lfsr_taps(BITS));

    always_ff @(posedge clk) begin
        if (reset) rnd <= BITS'(RNG_SEED);
        else       rnd <= {rnd[BITS-2:0], ^(rnd & TAPS)};
    end
endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing one LFSR value per one-cycle grant pulse.
module rng_arbiter import rng_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int BITS    = BITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    rng_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt, elig;
    logic [BITS-1:0]    rnd_q, rnd_nxt, rng_val;
    logic [PW-1:0]      ptr, ptr_nxt, win;
    logic               found;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    pseudo_rng #(.BITS(BITS)) u_rng (
        .clk   (clk),
        .reset (reset),
        .rnd   (rng_val)
    );

    // Returns {found, index}: first eligible bit at or after p, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] e, input logic [PW-1:0] p);
        logic [PW:0] r;
        int          idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (e[idx]) r = {1'b1, idx[PW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        rnd_nxt   = rnd_q;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        // The requester being granted right now must not win again at this edge.
        elig      = bus.req & ~((state == GRANT) ? gnt_q : '0);
        {found, win} = rr_pick(elig, ptr);
        if (!bus.pause && found) begin
            state_nxt    = GRANT;
            gnt_nxt[win] = 1'b1;
            rnd_nxt      = rng_val;
            ptr_nxt      = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            if (cnt != '1) cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt_q <= '0;
            rnd_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            rnd_q <= rnd_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rnd_out     = rnd_q;
    assign bus.grant_count = cnt;
endmodule

// File: tb/tb_rng_arbiter.sv
// Directed checks of grant order, random values, pause, reset and count saturation.
module tb_rng_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [4:0] model, mprev, saved;

    always #5 clk = ~clk;

    rng_arbiter_if #(.NUM_REQ(4), .BITS(5)) bus ();

    rng_arbiter #(.NUM_REQ(4), .BITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference LFSR x^5+x^3+1 seeded at 22; mprev is the value the DUT captures at an edge.
    always @(posedge clk) begin
        mprev <= model;
        model <= reset ? 5'd22 : {model[3:0], model[4] ^ model[2]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.pause = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_rnd", 32'(bus.rnd_out), 0);
        chk("rst_cnt", 32'(bus.grant_count), 0);

        // Single request
        reset   = 1'b0;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        chk("single_rnd", 32'(bus.rnd_out), 22);
        chk("single_cnt", 32'(bus.grant_count), 1);
        saved   = bus.rnd_out;
        bus.req = '0;
        @(negedge clk);
        chk("single_idle_gnt", 32'(bus.gnt), 0);
        chk("single_idle_rnd", 32'(bus.rnd_out), 32'(saved));

        // All requesting, each drops after its grant
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("all_gnt%0d", i), 32'(bus.gnt), 32'(1) << i);
            chk($sformatf("all_rnd%0d", i), 32'(bus.rnd_out), 32'(mprev));
            bus.req[i] = 1'b0;
        end
        chk("all_cnt", 32'(bus.grant_count), 4);
        @(negedge clk);
        chk("all_idle", 32'(bus.gnt), 0);

        // Fairness with two requesters held
        bus.req = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("fair%0d", i), 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h8);
        end
        chk("fair_cnt", 32'(bus.grant_count), 10);
        bus.req = '0;
        @(negedge clk);

        // Pause holds off grants while the LFSR keeps running
        bus.pause = 1'b1;
        bus.req   = 4'b0010;
        saved     = model;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("pause%0d", i), 32'(bus.gnt), 0);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        chk("unpause_gnt", 32'(bus.gnt), 32'h2);
        chk("unpause_rnd", 32'(bus.rnd_out), 32'(mprev));
        chk("unpause_cnt", 32'(bus.grant_count), 11);
        bus.req = '0;
        @(negedge clk);

        // Reset in the middle of a grant
        bus.req = 4'b0100;
        @(negedge clk);
        chk("midrst_pre", 32'(bus.gnt), 32'h4);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(bus.gnt), 0);
        chk("midrst_rnd", 32'(bus.rnd_out), 0);
        chk("midrst_cnt", 32'(bus.grant_count), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_regnt", 32'(bus.gnt), 32'h4);
        chk("midrst_reseed", 32'(bus.rnd_out), 22);
        bus.req = '0;

        // Saturation of the grant counter
        do_reset();
        bus.req = 4'b1001;
        repeat (65535) @(negedge clk);
        chk("sat_reach", 32'(bus.grant_count), 32'hFFFF);
        repeat (5) @(negedge clk);
        chk("sat_hold", 32'(bus.grant_count), 32'hFFFF);
        chk("sat_still_gnt", 32'(bus.gnt != 0), 1);
        bus.req = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
